ins_encoder: RTL
================

# ins_encoder

Pipelined instruction-word encoder. It takes decoded fields (opcode, registers, funct3, 64-bit signed immediate) and packs them into 32-bit instruction words whose immediate bits the core's immediate extractor recovers exactly. Each word is tagged with a sequential instruction-memory word address. It sits between the test/boot loader and instruction memory, with valid/ready handshakes on both sides.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input fields valid
- in_ready  out  1  block accepts input this cycle
- in_opcode  in  7  opcode; bits [5:4] select format
- in_rd  in  5  destination register (I format only)
- in_funct3  in  3  funct3
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2 (S/B formats)
- in_imm  in  64  signed immediate, in the extractor's units
- out_valid  out  1  encoded word valid
- out_ready  in  1  sink accepts word
- out_ins  out  32  encoded instruction
- out_addr  out  ADDR_W  word address of out_ins
- out_err  out  1  immediate of this word was out of range
- err_cnt  out  8  count of out-of-range words, saturates at 255
- full  out  1  2^ADDR_W words accepted; sticky until reset

## Operation
- Format is selected exactly as the extractor decodes it:
  - B if opcode[5]=1
  - else S if opcode[4]=1
  - else I
- Common fields for every format: ins[6:0]=opcode, ins[14:12]=funct3, ins[19:15]=rs1.
- B format:
  - ins[30:25]=imm[9:4], ins[11:8]=imm[3:0]
  - ins[31]=ins[7]=imm[9]
  - ins[24:20]=rs2
  - Legal range: imm[63:9] all equal, i.e. [-512, 511]
- S format:
  - ins[31:25]=imm[11:5], ins[11:7]=imm[4:0]
  - ins[24:20]=rs2
  - Legal range: imm[63:11] all equal, i.e. [-2048, 2047]
- I format:
  - ins[31:20]=imm[11:0], ins[11:7]=rd
  - Legal range: same as S
- Out-of-range immediate: the word is still emitted with truncated bits and out_err=1 for that word. err_cnt increments when the word is accepted at input (range check happens in S1).
- Two-stage pipeline:
  - S1 registers the fields, the format, the range flag and the address.
  - S2 registers out_ins, out_addr and out_err.
- Address counter: starts at 0 and increments on each input handshake (in_valid & in_ready). The word accepted when the counter equals 2^ADDR_W-1 sets full; the counter does not wrap.
- Handshake:
  - s2_free = !out_valid | out_ready
  - S1 advances to S2 when s1_valid & s2_free
  - in_ready = !full & !reset & (!s1_valid | s2_free), combinational
- Output hold: out_ins, out_addr and out_err stay stable while out_valid & !out_ready.
- Words are never dropped, duplicated or reordered. At most 2 words are in flight.
- full: remains 1 until reset. Words already in flight still drain normally.

## Timing
- Reset (sync, checked at rising edge):
  - out_valid=0, out_ins=0, out_addr=0, out_err=0, err_cnt=0, full=0
  - S1 emptied, address counter=0
  - in_ready=0 while reset is high, 1 in the first cycle after
- Latency: input handshake at edge N gives out_valid=1 after edge N+1, with the word visible in cycle N+1..N+2. Two register stages in total.
- Throughput: 1 word/cycle with out_ready held high.
- Simultaneous S2 drain and S1 advance in the same cycle: allowed, no bubble.
- Reset mid-stream: in-flight words are discarded and not emitted. Numbering restarts at address 0.
- err_cnt at 255: holds at 255.

## Test plan
- I format, opcode=0x03, rd=5, funct3=3, rs1=2, imm=-8 -> out_ins=0xFF813283, out_addr=0, out_err=0, two cycles after acceptance.
- S format, opcode=0x13, funct3=0, rs1=1, rs2=2, imm=0x7FF -> out_ins=0x7E208F93. Then the same fields with imm=2048 -> out_err=1, ins[31:25]=0x40, err_cnt=1.
- B format, opcode=0x63, funct3=0, rs1=1, rs2=2, imm=-2 -> out_ins=0xFE208EE3. Feeding this word through the extractor gives 64'hFFFF_FFFF_FFFF_FFFE.
- Back-to-back stream of 10 words with out_ready low for cycles 3-7:
  - in_ready drops once both stages hold words
  - outputs are in order with addresses 0..9 and none lost or duplicated
  - out_ins stays stable while stalled
- ADDR_W=2, in_valid held high for 6 words:
  - exactly 4 accepted (addresses 0..3), then full=1 and in_ready=0
  - all 4 words are emitted
  - reset clears full and the next word gets address 0
- Reset asserted while 2 words are in flight with out_ready=0 -> next cycle out_valid=0, err_cnt=0, and the in-flight words never appear.

Source files
------------

// File: rtl/ins_encoder.sv
`default_nettype none
// ============================================================================
// Module      : ins_encoder
// Description : Two-stage encoder packing decoded I/S/B fields into 32-bit
//               instruction words tagged with sequential word addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module ins_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [63:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_ins,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_cnt,
    output logic              full
);

    localparam logic [1:0] FMT_I = 2'd0;
    localparam logic [1:0] FMT_S = 2'd1;
    localparam logic [1:0] FMT_B = 2'd2;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              full_q, full_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              s1_valid_q, s1_valid_d;
    logic              out_valid_q, out_valid_d;

    logic [6:0]        s1_opcode_q;
    logic [4:0]        s1_rd_q;
    logic [2:0]        s1_funct3_q;
    logic [4:0]        s1_rs1_q;
    logic [4:0]        s1_rs2_q;
    logic [11:0]       s1_imm_q;
    logic [1:0]        s1_fmt_q;
    logic              s1_err_q;
    logic [ADDR_W-1:0] s1_addr_q;

    logic [31:0]       out_ins_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              out_err_q;

    logic [1:0]        w_in_fmt;
    logic              w_in_legal;
    logic              w_accept;
    logic              w_s2_free;
    logic              w_s1_adv;
    logic [31:0]       w_enc;

    // Format priority mirrors the immediate extractor: bit 5 wins over bit 4.
    always_comb begin
        w_in_fmt   = FMT_I;
        w_in_legal = (&in_imm[63:11]) | ~(|in_imm[63:11]);
        if (in_opcode[5]) begin
            w_in_fmt   = FMT_B;
            w_in_legal = (&in_imm[63:9]) | ~(|in_imm[63:9]);
        end else if (in_opcode[4]) begin
            w_in_fmt   = FMT_S;
        end
    end

    assign w_s2_free = ~out_valid_q | out_ready;
    assign w_s1_adv  = s1_valid_q & w_s2_free;
    assign in_ready  = ~full_q & ~reset & (~s1_valid_q | w_s2_free);
    assign w_accept  = in_valid & in_ready;

    always_comb begin
        w_enc = '0;
        case (s1_fmt_q)
            FMT_B:   w_enc = {s1_imm_q[9], s1_imm_q[9:4], s1_rs2_q, s1_rs1_q,
                              s1_funct3_q, s1_imm_q[3:0], s1_imm_q[9], s1_opcode_q};
            FMT_S:   w_enc = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q,
                              s1_funct3_q, s1_imm_q[4:0], s1_opcode_q};
            default: w_enc = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q,
                              s1_rd_q, s1_opcode_q};
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        full_d      = full_q;
        err_cnt_d   = err_cnt_q;
        s1_valid_d  = w_accept | (s1_valid_q & ~w_s1_adv);
        out_valid_d = w_s1_adv | (out_valid_q & ~out_ready);
        if (w_accept) begin
            // The last address marks the memory full; the counter parks there.
            if (addr_q == {ADDR_W{1'b1}}) begin
                full_d = 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
            if (!w_in_legal && err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            full_q      <= 1'b0;
            err_cnt_q   <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_opcode_q <= '0;
            s1_rd_q     <= '0;
            s1_funct3_q <= '0;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s1_imm_q    <= '0;
            s1_fmt_q    <= FMT_I;
            s1_err_q    <= 1'b0;
            s1_addr_q   <= '0;
            out_ins_q   <= '0;
            out_addr_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            full_q      <= full_d;
            err_cnt_q   <= err_cnt_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (w_accept) begin
                s1_opcode_q <= in_opcode;
                s1_rd_q     <= in_rd;
                s1_funct3_q <= in_funct3;
                s1_rs1_q    <= in_rs1;
                s1_rs2_q    <= in_rs2;
                s1_imm_q    <= in_imm[11:0];
                s1_fmt_q    <= w_in_fmt;
                s1_err_q    <= ~w_in_legal;
                s1_addr_q   <= addr_q;
            end
            if (w_s1_adv) begin
                out_ins_q  <= w_enc;
                out_addr_q <= s1_addr_q;
                out_err_q  <= s1_err_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ins   = out_ins_q;
    assign out_addr  = out_addr_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;
    assign full      = full_q;

endmodule
`default_nettype wire
